sig_dump_ctrl: RTL and testbench
================================

SIG_DUMP_CTRL -- requirements
Module: sig_dump_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high (ports clk, rst).
REQ-002 The block SHALL have these parameters (name, default, meaning):
- AW, 32, address width.
- DW, 32, data width; byte lanes NB=DW/8.
- TIMEOUT, 1024, watchdog cycles.
- DCATCH_BASE, 'h1000, byte address of data-RAM word 0.
- BEGIN_ADDR, 'h10000008, begin_signature register address.
- END_ADDR, 'h1000000C, end_signature register address.
- FLAG_ADDR, 'h10000010, end-flag register address.
- MAX_WORDS, 1024, data-RAM depth in words.
- DUMP_ON_TIMEOUT, 0, 1 = dump signature after timeout as well.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, sync active-high reset.
- st_valid, in, 1, store snoop strobe.
- st_addr, in, AW, store byte address.
- st_data, in, DW, store data.
- st_be, in, NB, store byte enables.
- rd_en, out, 1, data-RAM read request.
- rd_addr, out, clog2(MAX_WORDS), word index.
- rd_data, in, DW, read data, valid exactly 1 cycle after rd_en.
- out_valid, out, 1, signature word valid.
- out_data, out, DW, signature word.
- out_last, out, 1, final word marker.
- out_ready, in, 1, consumer ready.
- busy, out, 1, dump in progress.
- done, out, 1, sticky completion.
- timeout, out, 1, sticky watchdog expiry.
- range_err, out, 1, sticky bad signature window.

Function
REQ-004 States SHALL be MONITOR, CALC, RD, CAP, OUT, DONE.
REQ-005 In MONITOR, a store with st_valid=1 to BEGIN_ADDR, END_ADDR or FLAG_ADDR SHALL merge st_data into the matching internal register per st_be byte lane, taking effect the next cycle.
REQ-006 Stores to other addresses, and all stores outside MONITOR, SHALL be ignored.
REQ-007 MONITOR->CALC SHALL occur the cycle after the merged flag register equals 1.
REQ-008 The watchdog SHALL count cycles in MONITOR from reset release; at count TIMEOUT-1 it SHALL set timeout and go to CALC if DUMP_ON_TIMEOUT=1, else DONE.
REQ-009 If the flag store and watchdog expiry coincide, the flag SHALL win and timeout SHALL stay 0.
REQ-010 CALC (1 cycle) SHALL compute start=(begin-DCATCH_BASE)/NB and count=(end-begin)/NB, both unsigned and truncating.
REQ-011 If end<=begin, CALC SHALL go to DONE with zero words and no error.
REQ-012 If begin<DCATCH_BASE or start+count>MAX_WORDS, CALC SHALL set range_err and go to DONE with zero words.
REQ-013 Otherwise CALC SHALL go to RD.
REQ-014 RD SHALL assert rd_en for one cycle with rd_addr=start+i, then go to CAP.
REQ-015 CAP SHALL load rd_data into out_data, set out_valid=1, set out_last=(i==count-1), and go to OUT.
REQ-016 OUT SHALL hold out_valid, out_data and out_last stable until out_valid&&out_ready.
REQ-017 On that handshake, OUT SHALL clear out_valid, increment i, and go to DONE if last, else to RD.
REQ-018 Words SHALL leave in ascending address order, exactly count words, one per 3 cycles minimum.
REQ-019 busy SHALL be 1 in CALC, RD, CAP and OUT.
REQ-020 done SHALL be 1 in DONE; DONE SHALL be absorbing until rst.
REQ-021 rd_en and out_valid SHALL be 0 in all states other than RD and CAP/OUT respectively.

Reset
REQ-022 While rst=1, the FSM SHALL go to MONITOR, clear all internal registers and the watchdog, and drive every output to 0.
REQ-023 rst asserted mid-dump SHALL abort at the next edge with no further words output.

Verification
REQ-024 Stores begin=0x2000, end=0x2090, then flag=1; RAM[0x400+k]=k -> 36 words 0..35 in order, out_last on word 35, done=1, timeout=0.
REQ-025 Same as REQ-024 with out_ready toggling 1/0 randomly -> identical data, each word held stable while stalled, no drops or duplicates.
REQ-026 No flag store for 1024 cycles with DUMP_ON_TIMEOUT=0 -> timeout=1 and done=1 on cycle 1024, no out_valid.
REQ-027 begin=0x0800 (below base) then flag=1 -> range_err=1, done=1, zero words; separately, end==begin -> done=1, zero words, range_err=0.
REQ-028 Flag written as two byte-stores (be=0001 with data 1, then be=1110 with 0) -> dump starts only after the second store; rst asserted during word 5 -> all outputs 0 next cycle, FSM in MONITOR.

Source files
------------

// File: rtl/sig_dump_ctrl.sv
// rtl/sig_dump_ctrl.sv - snoops signature window stores, then streams the signature words out of data RAM
module sig_dump_ctrl #(
    parameter int            AW              = 32,
    parameter int            DW              = 32,
    parameter int            TIMEOUT         = 1024,
    parameter logic [AW-1:0] DCATCH_BASE     = 'h1000,
    parameter logic [AW-1:0] BEGIN_ADDR      = 'h10000008,
    parameter logic [AW-1:0] END_ADDR        = 'h1000000C,
    parameter logic [AW-1:0] FLAG_ADDR       = 'h10000010,
    parameter int            MAX_WORDS       = 1024,
    parameter bit            DUMP_ON_TIMEOUT = 1'b0,
    localparam int           NB              = DW / 8,
    localparam int           IW              = $clog2(MAX_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    input  logic [NB-1:0] st_be,
    output logic          rd_en,
    output logic [IW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic          range_err
);

    localparam int            SH     = $clog2(NB);
    localparam int            WW     = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] BASE_D = DW'(DCATCH_BASE);
    localparam logic [DW:0]   MAXW   = (DW + 1)'(MAX_WORDS);
    localparam logic [WW-1:0] WD_END = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {MONITOR, CALC, RD, CAP, OUT, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] begin_q, end_q, flag_q;
    logic [DW-1:0] begin_nxt, end_nxt, flag_nxt;
    logic [DW-1:0] start_q, count_q, idx_q;
    logic [WW-1:0] wd_q;
    logic          snoop;
    logic          last;
    logic          set_timeout, set_rerr, load_calc;
    logic [DW-1:0] start_full, cnt_full;
    logic [DW:0]   reach;
    logic          bad;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] d,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        end
        return r;
    endfunction

    // Stores are only honoured while snooping; anything after the flag is ignored.
    assign snoop     = st_valid && (state == MONITOR);
    assign begin_nxt = (snoop && st_addr == BEGIN_ADDR) ? merge(begin_q, st_data, st_be) : begin_q;
    assign end_nxt   = (snoop && st_addr == END_ADDR)   ? merge(end_q,   st_data, st_be) : end_q;
    assign flag_nxt  = (snoop && st_addr == FLAG_ADDR)  ? merge(flag_q,  st_data, st_be) : flag_q;

    // An empty or inverted window contributes zero words to the range check.
    assign start_full = (begin_q - BASE_D) >> SH;
    assign cnt_full   = (end_q > begin_q) ? ((end_q - begin_q) >> SH) : '0;
    assign reach      = {1'b0, start_full} + {1'b0, cnt_full};
    assign bad        = (begin_q < BASE_D) || (reach > MAXW);

    assign last      = (idx_q == count_q - DW'(1));
    assign rd_en     = (state == RD);
    assign rd_addr   = (state == RD) ? IW'(start_q + idx_q) : '0;
    assign busy      = (state == CALC) || (state == RD) || (state == CAP) || (state == OUT);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= MONITOR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        set_timeout = 1'b0;
        set_rerr    = 1'b0;
        load_calc   = 1'b0;
        case (state)
            MONITOR: begin
                // A flag landing in the expiry cycle still wins over the watchdog.
                if (flag_q == DW'(1)) begin
                    state_nxt = CALC;
                end else if (wd_q == WD_END && flag_nxt != DW'(1)) begin
                    set_timeout = 1'b1;
                    state_nxt   = DUMP_ON_TIMEOUT ? CALC : DONE;
                end
            end
            CALC: begin
                if (bad) begin
                    set_rerr  = 1'b1;
                    state_nxt = DONE;
                end else if (cnt_full == '0) begin
                    state_nxt = DONE;
                end else begin
                    load_calc = 1'b1;
                    state_nxt = RD;
                end
            end
            RD:      state_nxt = CAP;
            CAP:     state_nxt = OUT;
            OUT: begin
                if (out_ready) state_nxt = last ? DONE : RD;
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = MONITOR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            begin_q   <= '0;
            end_q     <= '0;
            flag_q    <= '0;
            wd_q      <= '0;
            start_q   <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            timeout   <= 1'b0;
            range_err <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            begin_q <= begin_nxt;
            end_q   <= end_nxt;
            flag_q  <= flag_nxt;
            if (state == MONITOR) wd_q <= wd_q + WW'(1);
            if (set_timeout) timeout   <= 1'b1;
            if (set_rerr)    range_err <= 1'b1;
            if (load_calc) begin
                start_q <= start_full;
                count_q <= cnt_full;
                idx_q   <= '0;
            end
            if (state == CAP) begin
                out_data  <= rd_data;
                out_valid <= 1'b1;
                out_last  <= last;
            end
            if (state == OUT && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                idx_q     <= idx_q + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sig_dump_ctrl.sv
// tb/tb_sig_dump_ctrl.sv - directed bench for sig_dump_ctrl
module tb_sig_dump_ctrl;

    localparam logic [31:0] A_BEGIN = 32'h10000008;
    localparam logic [31:0] A_END   = 32'h1000000C;
    localparam logic [31:0] A_FLAG  = 32'h10000010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [3:0]  st_be = '0;
    logic        rd_en;
    logic [10:0] rd_addr;
    logic [31:0] rd_data = '0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready = 1'b0;
    logic        busy, done, timeout, range_err;

    int n_vec = 0;
    int n_err = 0;

    sig_dump_ctrl #(.MAX_WORDS(2048)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .done(done), .timeout(timeout), .range_err(range_err)
    );

    always #5 clk = ~clk;

    // RAM[0x400+k] = k; junk when not read so stale captures show up.
    always @(posedge clk) begin
        if (rd_en) rd_data <= 32'(rd_addr) - 32'h400;
        else       rd_data <= 32'hDEADBEEF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        st_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_be    = be;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic collect(input int nexp, input bit stall, input int abort_at);
        int          k = 0;
        int          budget = 0;
        bit          prev_stall = 1'b0;
        logic [31:0] held = '0;
        while (done !== 1'b1 && budget < 600) begin
            if (abort_at >= 0 && k == abort_at && out_valid) begin
                out_ready = 1'b0;
                return;
            end
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", out_data, held);
            end
            if (out_valid && out_ready) begin
                check("word", out_data, 32'(k));
                check("last", 32'(out_last), 32'(k == nexp - 1));
                k++;
            end
            prev_stall = out_valid && !out_ready;
            held       = out_data;
            tick();
            budget++;
        end
        out_ready = 1'b0;
        check("word_count", 32'(k), 32'(nexp));
    endtask

    initial begin
        bit seen;
        bit early;

        // Reset state and a plain 36-word dump
        do_reset();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_flags", {30'd0, timeout, range_err}, 0);
        check("rst_rd_en", 32'(rd_en), 0);
        store(A_BEGIN, 32'h2000, 4'hF);
        store(A_END, 32'h2090, 4'hF);
        store(A_FLAG, 32'h1, 4'hF);
        collect(36, 1'b0, -1);
        check("d1_done", 32'(done), 1);
        check("d1_timeout", 32'(timeout), 0);
        check("d1_rerr", 32'(range_err), 0);
        check("d1_busy", 32'(busy), 0);

        // Same dump under random back-pressure
        do_reset();
        store(A_BEGIN, 32'h2000, 4'hF);
        store(A_END, 32'h2090, 4'hF);
        store(A_FLAG, 32'h1, 4'hF);
        collect(36, 1'b1, -1);
        check("d2_done", 32'(done), 1);
        check("d2_timeout", 32'(timeout), 0);

        // Watchdog expiry with no flag
        do_reset();
        seen  = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 1023; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
            if (done) early = 1'b1;
        end
        check("wd_early_done", 32'(early), 0);
        check("wd_pre_done", 32'(done), 0);
        tick();
        check("wd_done", 32'(done), 1);
        check("wd_timeout", 32'(timeout), 1);
        check("wd_no_valid", 32'(seen | out_valid), 0);

        // Flag store in the expiry cycle beats the watchdog
        do_reset();
        store(A_BEGIN, 32'h2000, 4'hF);
        store(A_END, 32'h2000, 4'hF);
        repeat (1021) tick();
        store(A_FLAG, 32'h1, 4'hF);
        repeat (3) tick();
        check("race_timeout", 32'(timeout), 0);
        check("race_done", 32'(done), 1);
        check("race_rerr", 32'(range_err), 0);

        // begin below the data-RAM base
        do_reset();
        store(A_BEGIN, 32'h0800, 4'hF);
        store(A_FLAG, 32'h1, 4'hF);
        collect(0, 1'b0, -1);
        check("low_rerr", 32'(range_err), 1);
        check("low_done", 32'(done), 1);

        // Empty window
        do_reset();
        store(A_BEGIN, 32'h2000, 4'hF);
        store(A_END, 32'h2000, 4'hF);
        store(A_FLAG, 32'h1, 4'hF);
        collect(0, 1'b0, -1);
        check("empty_rerr", 32'(range_err), 0);
        check("empty_done", 32'(done), 1);

        // Split flag store, then reset during word 5
        do_reset();
        store(A_BEGIN, 32'h2000, 4'hF);
        store(A_END, 32'h2090, 4'hF);
        st_valid = 1'b1;
        st_addr  = A_FLAG;
        st_data  = 32'h1;
        st_be    = 4'b0001;
        tick();
        check("split_busy1", 32'(busy), 0);
        st_data = 32'h0;
        st_be   = 4'b1110;
        tick();
        st_valid = 1'b0;
        check("split_busy2", 32'(busy), 1);
        collect(36, 1'b0, 5);
        check("abort_word", out_data, 32'd5);
        rst = 1'b1;
        tick();
        check("abort_valid", 32'(out_valid), 0);
        check("abort_data", out_data, 0);
        check("abort_misc", {25'd0, out_last, rd_en, busy, done, timeout, range_err, 1'b0}, 0);
        check("abort_rd_addr", 32'(rd_addr), 0);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid || busy || done) seen = 1'b1;
        end
        check("abort_idle", 32'(seen), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
